aes128_round_key_store: RTL and testbench
=========================================

# aes128_round_key_store

Round-key buffer that sits directly downstream of the AES-128 key expansion stage. On a new cipher key it starts the expander and steps it through all ten expansions with the start/request/valid handshake. It captures round keys 0..10 into an 11-entry register file. The cipher round controller then reads any round key by index in one cycle, in forward order for encryption or reverse order for decryption, without re-running the expansion.

## Interface
Parameters
- NUM_KEYS, 11, number of stored round keys, indices 0..NUM_KEYS-1; fixed at 11 for AES-128.

Ports
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; one clock; reset is synchronous and active-low.
- key_i  in  128  cipher key, big-endian (byte 0 in [127:120]); sampled when load_i is accepted.
- load_i  in  1  single-cycle request to expand and store key_i.
- busy_o  out  1  expansion in progress, or a load pending.
- ready_o  out  1  all 11 round keys valid for the current key.
- rd_en_i  in  1  read strobe.
- rd_idx_i  in  4  round index to read.
- rd_key_o  out  128  round key, in expander little-end byte order (byte 0 in [7:0]).
- rd_valid_o  out  1  one-cycle pulse qualifying rd_key_o.
- kx_key_o  out  128  key to the expander; latched copy of key_i.
- kx_start_o  out  1  expander start pulse.
- kx_key_req_o  out  1  expander next-key request pulse.
- kx_key_i  in  128  expander current round key.
- kx_valid_i  in  1  expander key valid.

## Operation
- FSM states: IDLE, KX_START, KX_WAIT, KX_REQ, KX_GAP, FULL.
- IDLE or FULL, load_i=1:
  - Latch key_i into kx_key_o, clear round counter rc to 0, clear ready_o.
  - Next state is KX_START.
- KX_START: kx_start_o=1 for exactly this cycle. Next state is KX_GAP.
- KX_GAP: one dead cycle so the expander's valid can update. Next state is KX_WAIT.
- KX_WAIT: wait for kx_valid_i=1, then write kx_key_i into entry rc.
  - If rc==10, next state is FULL.
  - Otherwise increment rc; next state is KX_REQ.
- KX_REQ: kx_key_req_o=1 for exactly this cycle. Next state is KX_GAP.
- FULL: ready_o=1; stay until a load.
- kx_start_o and kx_key_req_o are never high in the same cycle. Neither is asserted outside KX_START or KX_REQ.
- load_i while busy (states KX_*):
  - Latch key_i into a pending register and set the pending flag. The expander is not interrupted.
  - On reaching FULL with pending set, go directly to KX_START with the pending key. ready_o stays 0.
  - A later load_i overwrites the pending key (last wins).
- Reads:
  - rd_en_i is accepted only when ready_o=1. Otherwise it is ignored and rd_valid_o stays 0.
  - For rd_idx_i ≤ 10: rd_key_o = entry[rd_idx_i].
  - For rd_idx_i of 11..15: rd_key_o = 0 and rd_valid_o still pulses.
- load_i and rd_en_i in the same cycle while FULL: the read is served from the old keys, then ready_o falls.
- Storage is not cleared on load. Entries are only overwritten as they are captured.

## Timing
- Reset values: busy_o=0, ready_o=0, rd_valid_o=0, rd_key_o=0, kx_key_o=0, kx_start_o=0, kx_key_req_o=0. State is IDLE, rc=0, pending=0, all entries 0.
- Load accepted at edge N:
  - busy_o=1 and ready_o=0 from N+1.
  - kx_start_o high in cycle N+1.
- Entry capture happens on the edge where KX_WAIT sees kx_valid_i=1.
- ready_o rises one cycle after entry 10 is captured; busy_o falls in the same cycle, unless a load is pending.
- Read latency is 1 cycle: rd_en_i at edge N gives rd_key_o/rd_valid_o valid from N+1 for one cycle. rd_key_o holds its value afterwards.
- Reset mid-expansion returns everything to reset values on the next edge. The expander shares rst_n_i.

## Configuration
- AES128_KEY_STORE_CACHE_EN defined:
  - The store keeps the last fully expanded key.
  - load_i in FULL with key_i equal to it is a no-op: no kx_start_o, ready_o stays 1, busy_o stays 0.
  - A load in a KX_* state with a key equal to the key in flight is dropped, and any pending load is cancelled.
- Undefined: every accepted load_i re-expands, and ready_o drops the next cycle.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - Load, wait for ready_o.
  - Read idx 0 → rd_key_o = 3c4fcf098815f7aba6d2ae2816157e2b.
  - Read idx 10 → byte-reversed d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Exactly 1 kx_start_o and 10 kx_key_req_o pulses.
- Reverse read idx 10..0 on consecutive cycles → 11 back-to-back rd_valid_o pulses with correct keys, no bubbles.
- Read before ready_o, and read idx 13 when FULL → rd_valid_o=0, then rd_valid_o=1 with rd_key_o=0.
- Load key B at the 4th kx_key_req_o of key A:
  - Key A completes without ready_o asserting.
  - Key B expansion follows immediately.
  - Final entries equal key B's schedule.
- Reset asserted mid-KX_WAIT → all outputs return to reset values next cycle; a fresh load expands correctly.
- CACHE_EN: reload the same key in FULL → zero kx_start_o, ready_o continuously 1. Without CACHE_EN → ready_o drops one cycle, full re-expansion occurs.

Source files
------------

// File: rtl/aes128_round_key_store_if.sv
// -----------------------------------------------------------------------------
// aes128_round_key_store_if
// Handshake bundle between the round-key store and the AES-128 key expander.
// Signal names are from the store's point of view.
//
// Signals
//   kx_key_o      128  cipher key handed to the expander (big-endian)
//   kx_start_o      1  one-cycle start pulse
//   kx_key_req_o    1  one-cycle "advance to next round key" pulse
//   kx_key_i      128  expander's current round key (byte 0 in [7:0])
//   kx_valid_i      1  expander round key valid
//
// Modports
//   master : the round-key store (drives key/start/request)
//   slave  : the key expander    (drives round key/valid)
// -----------------------------------------------------------------------------
interface aes128_round_key_store_if;
   logic [127:0] kx_key_o;
   logic         kx_start_o;
   logic         kx_key_req_o;
   logic [127:0] kx_key_i;
   logic         kx_valid_i;

   modport master (
      output kx_key_o,
      output kx_start_o,
      output kx_key_req_o,
      input  kx_key_i,
      input  kx_valid_i
   );

   modport slave (
      input  kx_key_o,
      input  kx_start_o,
      input  kx_key_req_o,
      output kx_key_i,
      output kx_valid_i
   );
endinterface

// File: rtl/aes128_round_key_store.sv
// -----------------------------------------------------------------------------
// aes128_round_key_store
// Round-key buffer placed behind the AES-128 key expander. A load starts the
// expander and walks it through all ten expansions; round keys 0..10 are
// captured into an 11-entry register file. Once full, any round key can be
// read by index with one cycle of latency, in any order, without re-expanding.
//
// Ports
//   clk_i        in    1   clock
//   rst_n_i      in    1   synchronous active-low reset
//   key_i        in  128   cipher key, big-endian, sampled when a load is taken
//   load_i       in    1   request to expand and store key_i
//   busy_o       out   1   expansion in progress or a load pending
//   ready_o      out   1   all round keys valid for the current key
//   rd_en_i      in    1   read strobe (honoured only while ready_o=1)
//   rd_idx_i     in    4   round index to read; 11..15 return zero
//   rd_key_o     out 128   round key read, expander byte order (byte 0 in [7:0])
//   rd_valid_o   out   1   one-cycle pulse qualifying rd_key_o
//   kx           if        expander handshake (master modport)
//
// Build option
//   AES128_KEY_STORE_CACHE_EN : when defined, reloading the key that is already
//   expanded (or currently expanding) is ignored instead of re-expanding.
// -----------------------------------------------------------------------------
module aes128_round_key_store #(
   parameter int NUM_KEYS = 11
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [127:0]             key_i,
   input  logic                     load_i,
   output logic                     busy_o,
   output logic                     ready_o,
   input  logic                     rd_en_i,
   input  logic [3:0]               rd_idx_i,
   output logic [127:0]             rd_key_o,
   output logic                     rd_valid_o,
   aes128_round_key_store_if.master kx
);

   localparam logic [3:0] LAST_RC = 4'(NUM_KEYS - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      KX_START = 3'd1,
      KX_WAIT  = 3'd2,
      KX_REQ   = 3'd3,
      KX_GAP   = 3'd4,
      FULL     = 3'd5
   } state_t;

   state_t         state_r;
   state_t         state_nxt_s;
   logic [3:0]     rc_r;
   logic [3:0]     rc_nxt_s;
   logic [127:0]   kx_key_r;
   logic [127:0]   kx_key_nxt_s;
   logic [127:0]   pend_key_r;
   logic [127:0]   pend_key_nxt_s;
   logic           pend_r;
   logic           pend_nxt_s;
   logic           wr_en_s;
   logic           hit_s;
   logic [127:0]   key_mem_r [NUM_KEYS];
   logic [127:0]   rd_data_s;
   logic [127:0]   rd_key_r;
   logic           rd_valid_r;
   logic           busy_r;
   logic           ready_r;
   logic           kx_start_r;
   logic           kx_key_req_r;

   // True for the states in which the expander is being driven.
   function automatic logic is_kx(input state_t s);
      logic r;
      case (s)
         KX_START, KX_WAIT, KX_REQ, KX_GAP: r = 1'b1;
         default:                           r = 1'b0;
      endcase
      return r;
   endfunction

   // Cache hit: the offered key equals the key already expanded (FULL) or in
   // flight (KX_*). In IDLE nothing has been expanded, so there is never a hit.
   always_comb begin
      hit_s = 1'b0;
`ifdef AES128_KEY_STORE_CACHE_EN
      if ((state_r != IDLE) && (key_i == kx_key_r)) begin
         hit_s = 1'b1;
      end else begin
         hit_s = 1'b0;
      end
`else
      hit_s = 1'b0;
`endif
   end

   // Next-state and datapath control for the expansion sequencer.
   always_comb begin
      state_nxt_s    = state_r;
      rc_nxt_s       = rc_r;
      kx_key_nxt_s   = kx_key_r;
      pend_nxt_s     = pend_r;
      pend_key_nxt_s = pend_key_r;
      wr_en_s        = 1'b0;

      // A load during expansion never interrupts the expander; it is parked
      // and the latest one wins. A cache hit on the in-flight key cancels it.
      if (is_kx(state_r) && load_i) begin
         if (hit_s) begin
            pend_nxt_s = 1'b0;
         end else begin
            pend_nxt_s     = 1'b1;
            pend_key_nxt_s = key_i;
         end
      end else begin
         pend_nxt_s = pend_r;
      end

      case (state_r)
         IDLE, FULL: begin
            if (load_i && !hit_s) begin
               kx_key_nxt_s = key_i;
               rc_nxt_s     = 4'd0;
               state_nxt_s  = KX_START;
            end else begin
               state_nxt_s  = state_r;
            end
         end
         KX_START: begin
            state_nxt_s = KX_GAP;
         end
         KX_GAP: begin
            state_nxt_s = KX_WAIT;
         end
         KX_REQ: begin
            state_nxt_s = KX_GAP;
         end
         KX_WAIT: begin
            if (kx.kx_valid_i) begin
               wr_en_s = 1'b1;
               if (rc_r == LAST_RC) begin
                  // With a load parked, restart straight away so ready never
                  // advertises the superseded key.
                  if (pend_nxt_s) begin
                     kx_key_nxt_s = pend_key_nxt_s;
                     pend_nxt_s   = 1'b0;
                     rc_nxt_s     = 4'd0;
                     state_nxt_s  = KX_START;
                  end else begin
                     state_nxt_s  = FULL;
                  end
               end else begin
                  rc_nxt_s    = rc_r + 4'd1;
                  state_nxt_s = KX_REQ;
               end
            end else begin
               state_nxt_s = KX_WAIT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Sequencer state, round counter, latched and pending keys.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_r    <= IDLE;
         rc_r       <= 4'd0;
         kx_key_r   <= '0;
         pend_r     <= 1'b0;
         pend_key_r <= '0;
      end else begin
         state_r    <= state_nxt_s;
         rc_r       <= rc_nxt_s;
         kx_key_r   <= kx_key_nxt_s;
         pend_r     <= pend_nxt_s;
         pend_key_r <= pend_key_nxt_s;
      end
   end

   // Status and expander strobes, registered from the next state so each
   // strobe is high for exactly the cycle spent in its state.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         kx_start_r   <= 1'b0;
         kx_key_req_r <= 1'b0;
         ready_r      <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         kx_start_r   <= (state_nxt_s == KX_START);
         kx_key_req_r <= (state_nxt_s == KX_REQ);
         ready_r      <= (state_nxt_s == FULL);
         busy_r       <= is_kx(state_nxt_s) | pend_nxt_s;
      end
   end

   // Round-key register file; entries are only overwritten on capture.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            key_mem_r[i] <= '0;
         end
      end else if (wr_en_s) begin
         key_mem_r[rc_r] <= kx.kx_key_i;
      end else begin
         key_mem_r[rc_r] <= key_mem_r[rc_r];
      end
   end

   // Read mux; indices past the last round key return zero.
   always_comb begin
      rd_data_s = '0;
      if (rd_idx_i <= LAST_RC) begin
         rd_data_s = key_mem_r[rd_idx_i];
      end else begin
         rd_data_s = '0;
      end
   end

   // Read port: gated by the registered ready, so a read issued together with
   // a load in FULL still sees the old keys. rd_key_o holds between reads.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rd_valid_r <= 1'b0;
         rd_key_r   <= '0;
      end else if (rd_en_i && ready_r) begin
         rd_valid_r <= 1'b1;
         rd_key_r   <= rd_data_s;
      end else begin
         rd_valid_r <= 1'b0;
         rd_key_r   <= rd_key_r;
      end
   end

   assign busy_o          = busy_r;
   assign ready_o         = ready_r;
   assign rd_key_o        = rd_key_r;
   assign rd_valid_o      = rd_valid_r;
   assign kx.kx_key_o     = kx_key_r;
   assign kx.kx_start_o   = kx_start_r;
   assign kx.kx_key_req_o = kx_key_req_r;

   aes128_round_key_store_chk u_chk (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .kx_start   (kx_start_r),
      .kx_key_req (kx_key_req_r),
      .busy       (busy_r),
      .ready      (ready_r)
   );

endmodule

// -----------------------------------------------------------------------------
// aes128_round_key_store_chk
// Protocol properties of the round-key store outputs.
//
// Ports
//   clk_i, rst_n_i       clock and synchronous active-low reset
//   kx_start, kx_key_req expander strobes
//   busy, ready          store status
// -----------------------------------------------------------------------------
module aes128_round_key_store_chk (
   input logic clk_i,
   input logic rst_n_i,
   input logic kx_start,
   input logic kx_key_req,
   input logic busy,
   input logic ready
);

   a_strobe_excl: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      !(kx_start && kx_key_req));

   a_busy_ready_excl: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      !(busy && ready));

endmodule

// File: tb/tb_aes128_round_key_store.sv
// -----------------------------------------------------------------------------
// tb_aes128_round_key_store
// Directed bench for aes128_round_key_store with a behavioural key expander.
// Reads push their expected round key into a queue; a monitor pops and
// compares on every rd_valid_o pulse.
// -----------------------------------------------------------------------------
module tb_aes128_round_key_store;

   localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEY_C = 128'hdeadbeef0123456789abcdeffedcba98;
   localparam logic [127:0] A_RK0_LE  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
   localparam logic [127:0] A_RK10_LE = 128'ha60c63b6c80c3fe18925eec9a8f914d0;

   logic         clk_i      = 1'b0;
   logic         rst_n_i    = 1'b0;
   logic [127:0] key_i      = '0;
   logic         load_i     = 1'b0;
   logic         busy_o;
   logic         ready_o;
   logic         rd_en_i    = 1'b0;
   logic [3:0]   rd_idx_i   = 4'd0;
   logic [127:0] rd_key_o;
   logic         rd_valid_o;

   int n_checks = 0;
   int n_pass   = 0;
   int n_start  = 0;
   int n_req    = 0;
   int run_len  = 0;
   int max_run  = 0;
   logic [127:0] exp_q [$];

   always #5 clk_i = ~clk_i;

   aes128_round_key_store_if kxif ();

   aes128_round_key_store #(.NUM_KEYS(11)) dut (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .key_i      (key_i),
      .load_i     (load_i),
      .busy_o     (busy_o),
      .ready_o    (ready_o),
      .rd_en_i    (rd_en_i),
      .rd_idx_i   (rd_idx_i),
      .rd_key_o   (rd_key_o),
      .rd_valid_o (rd_valid_o),
      .kx         (kxif)
   );

   // Big-endian round key r: FIPS-197 A.1 schedule for KEY_A, a synthetic
   // per-round pattern for any other key (the store only captures).
   function automatic logic [127:0] sched_be(input logic [127:0] k, input int r);
      logic [7:0] b;
      if (k == KEY_A) begin
         case (r)
            0:  return 128'h2b7e151628aed2a6abf7158809cf4f3c;
            1:  return 128'ha0fafe1788542cb123a339392a6c7605;
            2:  return 128'hf2c295f27a96b9435935807a7359f67f;
            3:  return 128'h3d80477d4716fe3e1e237e446d7a883b;
            4:  return 128'hef44a541a8525b7fb671253bdb0bad00;
            5:  return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
            6:  return 128'h6d88a37a110b3efddbf98641ca0093fd;
            7:  return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
            8:  return 128'head27321b58dbad2312bf5607f8d292f;
            9:  return 128'hac7766f319fadc2128d12941575c006e;
            10: return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
            default: return '0;
         endcase
      end
      b = 8'(r * 17 + 1);
      return k ^ {16{b}};
   endfunction

   function automatic logic [127:0] byterev(input logic [127:0] k);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = k[127-8*i -: 8];
      return r;
   endfunction

   // Behavioural expander: valid drops on start/request and returns after a
   // round-dependent latency of 1..3 cycles.
   logic [127:0] xp_key_r;
   int           xp_round_r;
   int           xp_lat_r;
   always @(posedge clk_i) begin
      if (!rst_n_i) begin
         kxif.kx_valid_i <= 1'b0;
         xp_key_r        <= '0;
         xp_round_r      <= 0;
         xp_lat_r        <= 0;
      end else if (kxif.kx_start_o) begin
         xp_key_r        <= kxif.kx_key_o;
         xp_round_r      <= 0;
         xp_lat_r        <= 2;
         kxif.kx_valid_i <= 1'b0;
      end else if (kxif.kx_key_req_o) begin
         xp_round_r      <= xp_round_r + 1;
         xp_lat_r        <= 1 + ((xp_round_r + 1) % 3);
         kxif.kx_valid_i <= 1'b0;
      end else if (xp_lat_r != 0) begin
         xp_lat_r <= xp_lat_r - 1;
         if (xp_lat_r == 1) kxif.kx_valid_i <= 1'b1;
      end
   end
   assign kxif.kx_key_i = byterev(sched_be(xp_key_r, xp_round_r));

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: counts expander strobes and scores every read response.
   initial begin : monitor
      logic [127:0] e;
      forever begin
         @(negedge clk_i);
         if (kxif.kx_start_o === 1'b1) n_start++;
         if (kxif.kx_key_req_o === 1'b1) n_req++;
         if (rd_valid_o === 1'b1) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL rd_unexpected: rd_valid_o=1 key=%h, expected no read", rd_key_o);
            end else begin
               e = exp_q.pop_front();
               chk("rd_key", rd_key_o, e);
            end
         end else begin
            run_len = 0;
         end
      end
   end

   task automatic do_load(input logic [127:0] k);
      @(negedge clk_i);
      key_i  = k;
      load_i = 1'b1;
      @(negedge clk_i);
      load_i = 1'b0;
   endtask

   task automatic wait_ready(input string name);
      int cyc = 0;
      while (ready_o !== 1'b1 && cyc < 300) begin
         @(negedge clk_i);
         cyc++;
      end
      chk(name, 128'(ready_o), 128'd1);
   endtask

   task automatic rd(input logic [3:0] idx, input logic [127:0] e);
      @(negedge clk_i);
      rd_en_i  = 1'b1;
      rd_idx_i = idx;
      exp_q.push_back(e);
      @(negedge clk_i);
      rd_en_i = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"},   128'(busy_o),            128'd0);
      chk({tag, "_ready"},  128'(ready_o),           128'd0);
      chk({tag, "_rdv"},    128'(rd_valid_o),        128'd0);
      chk({tag, "_rdkey"},  rd_key_o,                128'd0);
      chk({tag, "_kxkey"},  kxif.kx_key_o,           128'd0);
      chk({tag, "_start"},  128'(kxif.kx_start_o),   128'd0);
      chk({tag, "_req"},    128'(kxif.kx_key_req_o), 128'd0);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int base_s;
      int base_r;
      int cnt;
      int cyc;
      int starts;
      int reqs;
      logic flag;

      // Reset values
      repeat (2) @(negedge clk_i);
      chk_reset_outputs("reset");
      rst_n_i = 1'b1;

      // Read while idle is ignored
      @(negedge clk_i);
      rd_en_i = 1'b1; rd_idx_i = 4'd0;
      @(negedge clk_i);
      rd_en_i = 1'b0;
      chk("rd_idle_valid", 128'(rd_valid_o), 128'd0);

      // FIPS-197 key: one start, ten requests
      base_s = n_start; base_r = n_req;
      do_load(KEY_A);
      chk("ld_busy",   128'(busy_o),          128'd1);
      chk("ld_ready",  128'(ready_o),         128'd0);
      chk("ld_start",  128'(kxif.kx_start_o), 128'd1);
      chk("ld_kx_key", kxif.kx_key_o,         KEY_A);
      // Read during expansion is ignored
      rd_en_i = 1'b1; rd_idx_i = 4'd0;
      @(negedge clk_i);
      rd_en_i = 1'b0;
      chk("rd_busy_valid", 128'(rd_valid_o), 128'd0);
      wait_ready("a_ready");
      chk("a_busy_done", 128'(busy_o),          128'd0);
      chk("a_starts",    128'(n_start - base_s), 128'd1);
      chk("a_reqs",      128'(n_req - base_r),   128'd10);
      rd(4'd0,  A_RK0_LE);
      rd(4'd10, A_RK10_LE);

      // Reverse order, back-to-back
      @(negedge clk_i);
      max_run = 0;
      for (int i = 10; i >= 0; i--) begin
         @(negedge clk_i);
         rd_en_i  = 1'b1;
         rd_idx_i = 4'(i);
         exp_q.push_back(byterev(sched_be(KEY_A, i)));
      end
      @(negedge clk_i);
      rd_en_i = 1'b0;
      @(negedge clk_i);
      chk("rev_run", 128'(max_run), 128'd11);

      // Out-of-range index returns zero with a valid pulse
      rd(4'd13, 128'd0);

      // Reload of the same key while FULL
      base_s = n_start; base_r = n_req;
`ifdef AES128_KEY_STORE_CACHE_EN
      do_load(KEY_A);
      flag = (ready_o !== 1'b1) || (busy_o !== 1'b0);
      repeat (20) begin
         @(negedge clk_i);
         if (ready_o !== 1'b1 || busy_o !== 1'b0) flag = 1'b1;
      end
      chk("cache_ready_held", 128'(flag),             128'd0);
      chk("cache_no_start",   128'(n_start - base_s), 128'd0);
`else
      do_load(KEY_A);
      chk("reload_ready", 128'(ready_o),         128'd0);
      chk("reload_busy",  128'(busy_o),          128'd1);
      chk("reload_start", 128'(kxif.kx_start_o), 128'd1);
      wait_ready("reload_done");
      chk("reload_starts", 128'(n_start - base_s), 128'd1);
      chk("reload_reqs",   128'(n_req - base_r),   128'd10);
`endif
      rd(4'd5, byterev(sched_be(KEY_A, 5)));

      // Load and read in the same FULL cycle: read sees the old keys
      @(negedge clk_i);
      key_i = KEY_C; load_i = 1'b1;
      rd_en_i = 1'b1; rd_idx_i = 4'd0;
      exp_q.push_back(A_RK0_LE);
      @(negedge clk_i);
      load_i = 1'b0; rd_en_i = 1'b0;
      chk("ldrd_ready", 128'(ready_o), 128'd0);
      wait_ready("c_ready");
      rd(4'd0,  byterev(sched_be(KEY_C, 0)));
      rd(4'd5,  byterev(sched_be(KEY_C, 5)));
      rd(4'd10, byterev(sched_be(KEY_C, 10)));

      // Load B at the 4th request of key A: A finishes silently, B follows
      do_load(KEY_A);
      cnt = 0; cyc = 0; reqs = 0;
      while (cnt < 4 && cyc < 300) begin
         @(negedge clk_i);
         if (kxif.kx_key_req_o === 1'b1) cnt++;
         cyc++;
      end
      reqs = cnt;
      key_i = KEY_B; load_i = 1'b1;
      starts = 0; flag = 1'b0; cyc = 0;
      while (cyc < 300) begin
         @(negedge clk_i);
         load_i = 1'b0;
         if (ready_o === 1'b1) break;
         if (kxif.kx_start_o === 1'b1) starts++;
         if (kxif.kx_key_req_o === 1'b1) reqs++;
         if (busy_o !== 1'b1) flag = 1'b1;
         cyc++;
      end
      chk("pend_ready",    128'(ready_o), 128'd1);
      chk("pend_starts",   128'(starts),  128'd1);
      chk("pend_reqs",     128'(reqs),    128'd20);
      chk("pend_busy_gap", 128'(flag),    128'd0);
      rd(4'd0,  byterev(sched_be(KEY_B, 0)));
      rd(4'd7,  byterev(sched_be(KEY_B, 7)));
      rd(4'd10, byterev(sched_be(KEY_B, 10)));

      // Reset while waiting on the expander
      do_load(KEY_C);
      cnt = 0; cyc = 0;
      while (cnt < 2 && cyc < 300) begin
         @(negedge clk_i);
         if (kxif.kx_key_req_o === 1'b1) cnt++;
         cyc++;
      end
      chk("mid_reqs_seen", 128'(cnt), 128'd2);
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b0;
      @(negedge clk_i);
      chk_reset_outputs("midrst");
      rst_n_i = 1'b1;
      do_load(KEY_A);
      wait_ready("post_rst_ready");
      rd(4'd0,  A_RK0_LE);
      rd(4'd10, A_RK10_LE);
      rd(4'd3,  byterev(sched_be(KEY_A, 3)));

      // Every expected read must have been answered
      repeat (3) @(negedge clk_i);
      chk("queue_drained", 128'(exp_q.size()), 128'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
